// File: rtl/iscas_chk_pkg.sv
//------------------------------------------------------------------------------
// iscas_chk_pkg : shared types, per-circuit sizes and slice-fold helper
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package iscas_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int C2670_OUT_WIDTH  = 140;
    localparam int C17_VEC_LENGTH   = 2;
    localparam int C432_VEC_LENGTH  = 7;
    localparam int C2670_VEC_LENGTH = 140;

    // Callers zero-extend the observed vector to FOLD_MAX_IN bits.
    localparam int FOLD_MAX_IN = 1024;
    localparam int FOLD_IDX_W  = $clog2(FOLD_MAX_IN);

    // Bit `pos` of the fold: XOR of every sig_w-wide slice at that position.
    function automatic logic fold_bit(
        input logic [FOLD_MAX_IN-1:0] data,
        input int                     sig_w,
        input int                     pos
    );
        logic acc;
        acc = 1'b0;
        for (int i = pos; i < FOLD_MAX_IN; i += sig_w) begin
            acc ^= data[FOLD_IDX_W'(i)];
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iscas_sig_reg.sv
//------------------------------------------------------------------------------
// iscas_sig_reg : shift-and-feedback signature register with fold input
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iscas_sig_reg #(
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY  = 32'h8020_0003
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [SIG_WIDTH-1:0] fold_in,
    output logic [SIG_WIDTH-1:0] sig_out
);

    logic [SIG_WIDTH-1:0] sig_q;
    logic [SIG_WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                  ^ fold_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_out = sig_q;

endmodule

`default_nettype wire

// File: rtl/iscas_response_checker.sv
//------------------------------------------------------------------------------
// iscas_response_checker : compares DUT output vectors to a preloaded response
//                          memory; reports error count, first fail, signature
// Revision               : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iscas_response_checker
    import iscas_chk_pkg::*;
#(
    parameter int                   OUT_WIDTH  = C2670_OUT_WIDTH,
    parameter int                   VEC_LENGTH = 8,
    parameter int                   SIG_WIDTH  = 32,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY   = 32'h8020_0003,
    parameter int                   CNT_WIDTH  = 16,
    localparam int                  ADDR_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exp_wr_en,
    input  logic [ADDR_WIDTH-1:0] exp_wr_addr,
    input  logic [OUT_WIDTH-1:0]  exp_wr_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  obs_valid,
    input  logic [OUT_WIDTH-1:0]  obs_data,
    output logic                  obs_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  first_fail_valid,
    output logic [ADDR_WIDTH-1:0] first_fail_idx,
    output logic [SIG_WIDTH-1:0]  signature
);

    chk_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  ff_valid_q, ff_valid_d;
    logic [ADDR_WIDTH-1:0] ff_idx_q, ff_idx_d;
    logic                  mismatch_q, mismatch_d;

    logic [OUT_WIDTH-1:0]  exp_mem [VEC_LENGTH];
    logic                  exp_we;
    logic                  accept;
    logic                  miss;
    logic                  launch;
    logic [FOLD_MAX_IN-1:0] obs_ext;
    logic [SIG_WIDTH-1:0]  fold;

    // Memory is only writable between runs; out-of-range addresses are dropped.
    assign exp_we = exp_wr_en && (state_q == IDLE)
                 && ({1'b0, exp_wr_addr} < (ADDR_WIDTH+1)'(VEC_LENGTH));

    always_ff @(posedge clk) begin
        if (exp_we) begin
            exp_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    assign obs_ext = FOLD_MAX_IN'(obs_data);

    for (genvar g = 0; g < SIG_WIDTH; g++) begin : g_fold
        assign fold[g] = fold_bit(obs_ext, SIG_WIDTH, g);
    end

    always_comb begin
        accept     = obs_valid && (state_q == RUN);
        miss       = accept && (obs_data != exp_mem[idx_q]);
        launch     = (state_q != RUN) && start && !abort;

        state_d    = state_q;
        idx_d      = idx_q;
        err_cnt_d  = err_cnt_q;
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        mismatch_d = miss;

        if (launch) begin
            state_d    = RUN;
            idx_d      = '0;
            err_cnt_d  = '0;
            ff_valid_d = 1'b0;
            ff_idx_d   = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
            if (miss) begin
                if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = idx_q;
                end
            end
            if (idx_q == ADDR_WIDTH'(VEC_LENGTH - 1)) begin
                state_d = DONE;
                idx_d   = '0;
            end
        end

        // Abort wins over everything, but keeps the statistics for debug.
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_cnt_q  <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_cnt_q  <= err_cnt_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            mismatch_q <= mismatch_d;
        end
    end

    iscas_sig_reg #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY)
    ) u_sig_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (launch),
        .en      (accept),
        .fold_in (fold),
        .sig_out (signature)
    );

    assign obs_ready        = (state_q == RUN);
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_cnt_q == '0);
    assign mismatch         = mismatch_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_iscas_response_checker.sv
//------------------------------------------------------------------------------
// tb_iscas_response_checker : randomized scoreboard bench for the checker
// Revision                  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_iscas_response_checker;

    localparam int          OW   = 140;
    localparam int          VL   = 8;
    localparam int          SW   = 32;
    localparam int          CW   = 16;
    localparam int          AW   = 3;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          M_IDLE = 0;
    localparam int          M_RUN  = 1;
    localparam int          M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          exp_wr_en = 1'b0;
    logic [AW-1:0] exp_wr_addr = '0;
    logic [OW-1:0] exp_wr_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          obs_valid = 1'b0;
    logic [OW-1:0] obs_data = '0;
    logic          obs_ready, busy, done, pass, mismatch;
    logic [CW-1:0] err_cnt;
    logic          first_fail_valid;
    logic [AW-1:0] first_fail_idx;
    logic [SW-1:0] signature;

    always #5 clk = ~clk;

    iscas_response_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exp_wr_en        (exp_wr_en),
        .exp_wr_addr      (exp_wr_addr),
        .exp_wr_data      (exp_wr_data),
        .start            (start),
        .abort            (abort),
        .obs_valid        (obs_valid),
        .obs_data         (obs_data),
        .obs_ready        (obs_ready),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch         (mismatch),
        .err_cnt          (err_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .signature        (signature)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the checker should be showing right now.
    logic [OW-1:0] m_mem [VL];
    int            m_state = M_IDLE;
    int            m_idx = 0;
    int            m_err = 0;
    bit            m_ffv = 1'b0;
    int            m_ffi = 0;
    logic [31:0]   m_sig = '0;

    typedef struct {
        bit ready;
        bit mis_next;
    } item_t;
    item_t sb_q[$];
    bit    flush = 1'b0;

    logic [OW-1:0] exp_w [VL];
    logic [OW-1:0] obs_w [VL];

    function automatic logic [31:0] fold_ref(input logic [OW-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int s = 0; s < OW; s += SW) f ^= 32'(d >> s);
        return f;
    endfunction

    function automatic logic [OW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[OW-1:0];
    endfunction

    // One clock of stimulus: verify visible state, queue the expected response, advance the model.
    task automatic step(input bit st, input bit ab, input bit v, input logic [OW-1:0] d,
                        input bit we = 1'b0, input int wa = 0, input logic [OW-1:0] wd = '0);
        bit acc, mis, last;
        @(posedge clk);
        #1;
        start = st; abort = ab; obs_valid = v; obs_data = d;
        exp_wr_en = we; exp_wr_addr = AW'(wa); exp_wr_data = wd;

        check("busy", busy, m_state == M_RUN);
        check("done", done, m_state == M_DONE);
        check("pass", pass, (m_state == M_DONE) && (m_err == 0));
        check("err_cnt", err_cnt, m_err);
        check("first_fail_valid", first_fail_valid, m_ffv);
        check("first_fail_idx", first_fail_idx, m_ffi);
        check("signature", signature, m_sig);

        acc  = (m_state == M_RUN) && v;
        mis  = acc && (d != m_mem[m_idx]);
        last = acc && (m_idx == VL - 1);
        sb_q.push_back('{ready: (m_state == M_RUN), mis_next: mis});

        if (acc) begin
            if (mis) begin
                if (m_err < (1 << CW) - 1) m_err++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffi = m_idx;
                end
            end
            m_sig = (m_sig << 1) ^ (m_sig[31] ? POLY : 32'h0) ^ fold_ref(d);
            m_idx = (m_idx + 1) % VL;
        end
        if (m_state == M_IDLE && we && wa < VL) m_mem[wa] = wd;

        if (ab) begin
            m_state = M_IDLE;
        end else if (m_state != M_RUN && st) begin
            m_state = M_RUN;
            m_idx = 0; m_err = 0; m_ffv = 1'b0; m_ffi = 0; m_sig = '0;
        end else if (last) begin
            m_state = M_DONE;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic load_mem();
        for (int i = 0; i < VL; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, i, exp_w[i]);
    endtask

    task automatic run_samples(input int gap_pct, input int start_pct);
        for (int i = 0; i < VL; i++) begin
            while ($urandom_range(99) < gap_pct) idle();
            step($urandom_range(99) < start_pct, 1'b0, 1'b1, obs_w[i]);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_obs_ready"}, obs_ready, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_mismatch"}, mismatch, 1'b0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_ffv"}, first_fail_valid, 1'b0);
        check({tag, "_ffi"}, first_fail_idx, 0);
        check({tag, "_signature"}, signature, 0);
    endtask

    task automatic async_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        rst_n = 1'b1;
        flush = 1'b1;
        m_state = M_IDLE; m_idx = 0; m_err = 0; m_ffv = 1'b0; m_ffi = 0; m_sig = '0;
    endtask

    // Monitor: mismatch must reflect the previous cycle's accepted sample.
    initial begin
        bit    prev;
        item_t it;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (flush) begin
                prev = 1'b0;
                sb_q.delete();
                flush = 1'b0;
            end else if (rst_n) begin
                check("mismatch", mismatch, prev);
                if (sb_q.size() > 0) begin
                    it = sb_q.pop_front();
                    check("obs_ready", obs_ready, it.ready);
                    prev = it.mis_next;
                end else begin
                    prev = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [OW-1:0] ones;
        ones = '1;

        #3;
        check_zero_outputs("reset");
        #19 rst_n = 1'b1;

        for (int i = 0; i < VL; i++) begin
            exp_w[i] = rand_word();
            obs_w[i] = exp_w[i];
        end
        load_mem();

        // Clean run, back-to-back samples.
        step(1'b1, 1'b0, 1'b0, '0);
        run_samples(0, 0);
        idle();
        check("clean_done", done, 1'b1);
        check("clean_pass", pass, 1'b1);
        check("clean_err", err_cnt, 0);
        check("clean_ffv", first_fail_valid, 1'b0);

        // Two corrupted samples, re-run from DONE.
        obs_w[3][0]   = ~obs_w[3][0];
        obs_w[6][139] = ~obs_w[6][139];
        step(1'b1, 1'b0, 1'b0, '0);
        run_samples(0, 0);
        idle();
        check("err2_cnt", err_cnt, 2);
        check("err2_ffi", first_fail_idx, 3);
        check("err2_ffv", first_fail_valid, 1'b1);
        check("err2_pass", pass, 1'b0);
        obs_w[3] = exp_w[3];
        obs_w[6] = exp_w[6];

        // Gapped valid stream.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < VL; i++) begin
            step(1'b0, 1'b0, 1'b1, obs_w[i]);
            idle();
            idle();
        end
        check("gap_pass", pass, 1'b1);

        // Single all-ones sample from a cleared signature.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, ones);
        idle();
        check("fold_sig", signature, 32'h0000_0FFF);
        step(1'b0, 1'b1, 1'b0, '0);

        // Abort beats start; stats survive the abort, a new start clears them.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, obs_w[0]);
        step(1'b0, 1'b0, 1'b1, obs_w[1] ^ 140'h1);
        step(1'b0, 1'b0, 1'b1, obs_w[2], 1'b1, 2, ~exp_w[2]);
        step(1'b0, 1'b0, 1'b1, obs_w[3]);
        step(1'b1, 1'b1, 1'b0, '0);
        idle();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_err_kept", err_cnt, 1);
        step(1'b1, 1'b0, 1'b0, '0);
        idle();
        check("restart_err", err_cnt, 0);
        check("restart_busy", busy, 1'b1);
        run_samples(20, 0);
        idle();
        check("after_abort_pass", pass, 1'b1);

        // Asynchronous reset mid-run; memory must survive it.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, obs_w[0] ^ 140'h2);
        step(1'b0, 1'b0, 1'b1, obs_w[1]);
        async_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        run_samples(0, 0);
        idle();
        check("post_rst_pass", pass, 1'b1);

        // Randomized runs with fresh memory, bit flips, gaps and stray starts.
        for (int r = 0; r < 8; r++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            for (int i = 0; i < VL; i++) begin
                exp_w[i] = rand_word();
                obs_w[i] = exp_w[i];
                if ($urandom_range(3) == 0) obs_w[i][$urandom_range(OW - 1)] ^= 1'b1;
            end
            load_mem();
            step(1'b1, 1'b0, 1'b0, '0);
            run_samples(30, 15);
            idle();
            idle();
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
